// File: rtl/prefix_adder_pipe_pkg.sv
// Shared constants and helpers for the pipelined Kogge-Stone adder.
// The ALU scoreboard uses calc_lat so that it agrees with the RTL latency.
package prefix_adder_pipe_pkg;

   // Ceiling log2 for elaboration-time sizing (value >= 1).
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

   // Cycles from input acceptance to out_valid: one register per prefix segment plus the sum register.
   function automatic int calc_lat(input int width, input int reg_every);
      return (clog2(width) + reg_every - 1) / reg_every + 1;
   endfunction

   // Index of the last prefix level evaluated before pipeline register 'seg' (seg >= 1).
   function automatic int seg_last_level(input int seg, input int reg_every, input int levels);
      return ((seg * reg_every < levels) ? seg * reg_every : levels) - 1;
   endfunction

endpackage

// File: rtl/prefix_adder_pipe_black_cell.sv
// Kogge-Stone black cell: merges a high (g,p) span with the adjacent lower span.
module prefix_black_cell (
   input  logic gh,
   input  logic ph,
   input  logic gl,
   input  logic pl,
   output logic g,
   output logic p
);

   assign g = gh | (ph & gl);
   assign p = ph & pl;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Position 0 of the prefix vectors is a virtual bit carrying the carry-in
// (g = c0, p = 0); operand bit i lives at position i+1.
module prefix_adder_pipe
   import prefix_adder_pipe_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int REG_EVERY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int LEVELS = clog2(WIDTH);
   localparam int SEGS   = (LEVELS + REG_EVERY - 1) / REG_EVERY;
   localparam int LAT    = calc_lat(WIDTH, REG_EVERY);
   localparam int STAGES = LAT + 1;   // prefix registers 0..SEGS plus the sum register
   localparam int POS    = WIDTH + 1;

   logic [STAGES-1:0] vld_reg;
   logic [STAGES-1:0] move;

   // Prefix pipeline registers: index 0 is the input stage, SEGS holds finished carries.
   logic [POS-1:0]   g_reg  [SEGS+1];
   logic [POS-1:0]   p_reg  [SEGS+1];
   logic [WIDTH-1:0] pb_reg [SEGS+1];   // raw bitwise propagate, needed for the final XOR

   logic [POS-1:0]   lvl_g [LEVELS];
   logic [POS-1:0]   lvl_p [LEVELS];

   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic [POS-1:0]   carry;
   logic [WIDTH-1:0] sum_next;
   logic             cout_next;
   logic             ovf_next;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;
   logic             ovf_reg;

   // Prefix tree: each level either starts from a pipeline register or chains from the level before.
   for (genvar gi = 0; gi < LEVELS; gi++) begin : g_level
      logic [POS-1:0] gin, pin, gout, pout;

      if (gi % REG_EVERY == 0) begin : g_from_reg
         assign gin = g_reg[gi / REG_EVERY];
         assign pin = p_reg[gi / REG_EVERY];
      end else begin : g_from_lvl
         assign gin = lvl_g[gi - 1];
         assign pin = lvl_p[gi - 1];
      end

      for (genvar gj = 0; gj < POS; gj++) begin : g_pos
         if (gj >= (1 << gi)) begin : g_cell
            prefix_black_cell u_cell (
               .gh (gin[gj]),
               .ph (pin[gj]),
               .gl (gin[gj - (1 << gi)]),
               .pl (pin[gj - (1 << gi)]),
               .g  (gout[gj]),
               .p  (pout[gj])
            );
         end else begin : g_pass
            assign gout[gj] = gin[gj];
            assign pout[gj] = pin[gj];
         end
      end

      assign lvl_g[gi] = gout;
      assign lvl_p[gi] = pout;
   end

   // Operand conditioning and final sum/flag formation.
   always_comb begin
      b_eff = sub ? ~b : b;
      c0    = sub ? 1'b1 : cin;
      // With WIDTH a power of two the tree spans only WIDTH positions, so the top
      // position stops one short of the virtual carry-in; fold it in here. Lower
      // positions already include position 0 and carry P = 0, so this is harmless there.
      carry     = g_reg[SEGS] | (p_reg[SEGS] & {POS{g_reg[SEGS][0]}});
      sum_next  = pb_reg[SEGS] ^ carry[WIDTH-1:0];
      cout_next = carry[WIDTH];
      ovf_next  = carry[WIDTH] ^ carry[WIDTH-1];
   end

   // A stage may load when it is empty or its contents move on this cycle.
   always_comb begin
      move = '0;
      move[STAGES-1] = !vld_reg[STAGES-1] || out_ready;
      for (int s = STAGES - 2; s >= 0; s--) begin
         move[s] = !vld_reg[s] || move[s+1];
      end
   end

   // Valid tracking and the result register; reset drops every in-flight beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_reg  <= '0;
         sum_reg  <= '0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else begin
         if (move[0]) vld_reg[0] <= in_valid;
         for (int s = 1; s < STAGES; s++) begin
            if (move[s]) vld_reg[s] <= vld_reg[s-1];
         end
         if (move[STAGES-1] && vld_reg[STAGES-2]) begin
            sum_reg  <= sum_next;
            cout_reg <= cout_next;
            ovf_reg  <= ovf_next;
         end
      end
   end

   // Prefix datapath registers; contents are qualified by vld_reg so they need no reset.
   always_ff @(posedge clk) begin
      if (move[0] && in_valid) begin
         g_reg[0]  <= {a & b_eff, c0};
         p_reg[0]  <= {a ^ b_eff, 1'b0};
         pb_reg[0] <= a ^ b_eff;
      end
      for (int s = 1; s <= SEGS; s++) begin
         if (move[s] && vld_reg[s-1]) begin
            g_reg[s]  <= lvl_g[seg_last_level(s, REG_EVERY, LEVELS)];
            p_reg[s]  <= lvl_p[seg_last_level(s, REG_EVERY, LEVELS)];
            pb_reg[s] <= pb_reg[s-1];
         end
      end
   end

   assign in_ready  = move[0];
   assign out_valid = vld_reg[STAGES-1];
   assign sum       = sum_reg;
   assign cout      = cout_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed bench for prefix_adder_pipe: main instance WIDTH=32/REG_EVERY=2 plus
// three parameter variants driven in parallel and checked against a behavioural sum.
module tb_prefix_adder_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid_m, in_valid_x;
   logic        out_ready_m, out_ready_x;
   logic [63:0] a, b;
   logic        cin, sub;

   logic        in_ready_m, out_valid_m, cout_m, ovf_m;
   logic [31:0] sum_m;
   logic        in_ready_8, out_valid_8, cout_8, ovf_8;
   logic [7:0]  sum_8;
   logic        in_ready_13, out_valid_13, cout_13, ovf_13;
   logic [12:0] sum_13;
   logic        in_ready_64, out_valid_64, cout_64, ovf_64;
   logic [63:0] sum_64;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   prefix_adder_pipe #(.WIDTH(32), .REG_EVERY(2)) dut_m (
      .clk(clk), .reset(reset), .in_valid(in_valid_m), .in_ready(in_ready_m),
      .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
      .out_valid(out_valid_m), .out_ready(out_ready_m),
      .sum(sum_m), .cout(cout_m), .ovf(ovf_m));

   prefix_adder_pipe #(.WIDTH(8), .REG_EVERY(1)) dut_8 (
      .clk(clk), .reset(reset), .in_valid(in_valid_x), .in_ready(in_ready_8),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
      .out_valid(out_valid_8), .out_ready(out_ready_x),
      .sum(sum_8), .cout(cout_8), .ovf(ovf_8));

   prefix_adder_pipe #(.WIDTH(13), .REG_EVERY(4)) dut_13 (
      .clk(clk), .reset(reset), .in_valid(in_valid_x), .in_ready(in_ready_13),
      .a(a[12:0]), .b(b[12:0]), .cin(cin), .sub(sub),
      .out_valid(out_valid_13), .out_ready(out_ready_x),
      .sum(sum_13), .cout(cout_13), .ovf(ovf_13));

   prefix_adder_pipe #(.WIDTH(64), .REG_EVERY(1)) dut_64 (
      .clk(clk), .reset(reset), .in_valid(in_valid_x), .in_ready(in_ready_64),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid_64), .out_ready(out_ready_x),
      .sum(sum_64), .cout(cout_64), .ovf(ovf_64));

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Behavioural reference: plain wide addition, overflow from operand/result signs.
   function automatic logic [65:0] model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                         input logic c, input logic s);
      logic [64:0] mask, am, bm, full;
      logic [63:0] sm;
      logic        c0v;
      mask = (65'd1 << w) - 65'd1;
      am   = {1'b0, av} & mask;
      bm   = (s ? {1'b0, ~bv} : {1'b0, bv}) & mask;
      c0v  = s ? 1'b1 : c;
      full = am + bm + {64'd0, c0v};
      sm   = full[63:0] & mask[63:0];
      return {(am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]), full[w], sm};
   endfunction

   // One beat into every instance; measure latency and result of each.
   task automatic apply_all(input string tag, input logic [63:0] av, input logic [63:0] bv,
                            input logic c, input logic s, input logic [31:0] exp_sum,
                            input logic exp_cout, input logic exp_ovf);
      int lat_m, lat_8, lat_13, lat_64;
      logic [65:0] got_m, got_8, got_13, got_64;
      lat_m = -1; lat_8 = -1; lat_13 = -1; lat_64 = -1;
      got_m = '0; got_8 = '0; got_13 = '0; got_64 = '0;
      @(negedge clk);
      a = av; b = bv; cin = c; sub = s;
      in_valid_m = 1'b1; in_valid_x = 1'b1;
      #1;
      check({tag, " in_ready"}, 72'({in_ready_m, in_ready_8, in_ready_13, in_ready_64}), 72'(4'hF));
      @(posedge clk);
      @(negedge clk);
      in_valid_m = 1'b0; in_valid_x = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid_m && lat_m < 0) begin lat_m = i; got_m = {ovf_m, cout_m, 32'd0, sum_m}; end
         if (out_valid_8 && lat_8 < 0) begin lat_8 = i; got_8 = {ovf_8, cout_8, 56'd0, sum_8}; end
         if (out_valid_13 && lat_13 < 0) begin lat_13 = i; got_13 = {ovf_13, cout_13, 51'd0, sum_13}; end
         if (out_valid_64 && lat_64 < 0) begin lat_64 = i; got_64 = {ovf_64, cout_64, sum_64}; end
      end
      check({tag, " lat32"}, 72'(lat_m), 72'(4));
      check({tag, " sum32"}, 72'(got_m[31:0]), 72'(exp_sum));
      check({tag, " cout32"}, 72'(got_m[64]), 72'(exp_cout));
      check({tag, " ovf32"}, 72'(got_m[65]), 72'(exp_ovf));
      check({tag, " lat8"}, 72'(lat_8), 72'(4));
      check({tag, " res8"}, 72'(got_8), 72'(model(8, av, bv, c, s)));
      check({tag, " lat13"}, 72'(lat_13), 72'(2));
      check({tag, " res13"}, 72'(got_13), 72'(model(13, av, bv, c, s)));
      check({tag, " lat64"}, 72'(lat_64), 72'(7));
      check({tag, " res64"}, 72'(got_64), 72'(model(64, av, bv, c, s)));
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic [65:0] rm;
      logic        rc, rs;
      int sent, recv, stale;
      logic saw_stall;

      reset = 1'b1; in_valid_m = 1'b0; in_valid_x = 1'b0;
      out_ready_m = 1'b1; out_ready_x = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst out_valid", 72'({out_valid_m, out_valid_8, out_valid_13, out_valid_64}), 72'(0));
      check("rst sum", 72'(sum_m), 72'(0));
      check("rst flags", 72'({cout_m, ovf_m}), 72'(0));
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst in_ready", 72'(in_ready_m), 72'(1));

      // Directed vectors with hand-computed 32-bit results
      apply_all("add5p3",   64'h5, 64'h3, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
      apply_all("chain_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      apply_all("ff_p1",    64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      apply_all("ovf_pos",  64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      apply_all("sub_ovf",  64'h8000_0000, 64'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      apply_all("sub3m5",   64'h3, 64'h5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      apply_all("sub_eq",   64'h1234_5678, 64'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      apply_all("sub_cin",  64'hA, 64'h3, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);

      // Backpressure: 10 beats back-to-back, output stalled for cycles 3..7
      sent = 0; recv = 0; saw_stall = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         out_ready_m = !(cyc >= 3 && cyc <= 7);
         in_valid_m  = (sent < 10);
         a = 64'(32'h1000_0000 + sent); b = 64'(sent * 3); cin = 1'b0; sub = 1'b0;
         #1;
         if (in_valid_m && !in_ready_m) saw_stall = 1'b1;
         if (out_valid_m && out_ready_m) begin
            check($sformatf("bp beat%0d", recv), 72'({ovf_m, cout_m, sum_m}),
                  72'({2'b00, 32'h1000_0000 + 32'(4 * recv)}));
            recv++;
         end
         if (in_valid_m && in_ready_m) sent++;
      end
      @(negedge clk);
      in_valid_m = 1'b0; out_ready_m = 1'b1;
      check("bp stall seen", 72'(saw_stall), 72'(1));
      check("bp sent", 72'(sent), 72'(10));
      check("bp received", 72'(recv), 72'(10));

      // Reset with three beats in flight
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid_m = 1'b1; a = 64'(k + 100); b = 64'h0; cin = 1'b0; sub = 1'b0;
      end
      @(negedge clk);
      in_valid_m = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("midrst out_valid", 72'(out_valid_m), 72'(0));
      check("midrst result", 72'({ovf_m, cout_m, sum_m}), 72'(0));
      reset = 1'b0;
      #1;
      check("midrst in_ready", 72'(in_ready_m), 72'(1));
      stale = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid_m) stale++;
      end
      check("midrst stale beats", 72'(stale), 72'(0));

      // Random vectors across all parameter sets
      for (int k = 0; k < 6; k++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         rc = 1'($urandom_range(1));
         rs = 1'($urandom_range(1));
         rm = model(32, ra, rb, rc, rs);
         apply_all($sformatf("rand%0d", k), ra, rb, rc, rs, rm[31:0], rm[64], rm[65]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
